// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the packet round-robin arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } arb_state_e;

    localparam int unsigned PKT_CNT_W = 16;

endpackage

// File: rtl/axis_pkt_rr_arbiter_rr_pick.sv
// Rotating-priority selector: first requester at or after ptr, modulo NUM_SRC.
module rr_pick #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ID_W    = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    idx,
    output logic               found
);

    logic [NUM_SRC-1:0] rot;
    int unsigned        sum;

    // Rotate the request vector so bit k is source (ptr+k) mod NUM_SRC, then take the lowest set bit.
    always_comb begin
        rot   = NUM_SRC'({req, req} >> ptr);
        idx   = '0;
        found = 1'b0;
        sum   = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = 32'(ptr) + k;
                if (sum >= NUM_SRC) begin
                    sum = sum - NUM_SRC;
                end
                idx = ID_W'(sum);
            end
        end
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-aware round-robin AXI-Stream merger with a single registered output stage.
module axis_pkt_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_W       = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data,
    input  logic [NUM_SRC-1:0]            s_axis_valid,
    input  logic [NUM_SRC-1:0]            s_axis_last,
    output logic [NUM_SRC-1:0]            s_axis_ready,
    output logic [DATA_WIDTH-1:0]         m_axis_data,
    output logic                          m_axis_valid,
    output logic                          m_axis_last,
    input  logic                          m_axis_ready,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic [PKT_CNT_W-1:0]          pkt_count
);

    arb_state_e               state_q, state_d;
    logic [ID_W-1:0]          grant_q, grant_d;
    logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     last_q, last_d;
    logic [PKT_CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_SRC-1:0]       gnt_oh;
    logic                     sel_valid;
    logic                     sel_last;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic                     out_free;
    logic                     accept;
    logic [ID_W-1:0]          pick_idx;
    logic                     pick_found;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (s_axis_valid),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Decode the grant into a one-hot mask and mux the granted source's beat.
    always_comb begin
        gnt_oh    = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            gnt_oh[i] = (grant_q == ID_W'(i));
            if (gnt_oh[i]) begin
                sel_valid = s_axis_valid[i];
                sel_last  = s_axis_last[i];
                sel_data  = s_axis_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign out_free     = !valid_q || m_axis_ready;
    assign s_axis_ready = (state_q == PKT && out_free) ? gnt_oh : '0;
    assign accept       = (state_q == PKT) && out_free && sel_valid;

    // Next-state: arbitration in IDLE, beat transfer and packet close in PKT, output register load/drain.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        last_d   = last_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = PKT;
                end
            end
            PKT: begin
                if (accept && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == ID_W'(NUM_SRC - 1)) ? '0 : grant_q + ID_W'(1);
                    cnt_d    = cnt_q + PKT_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            data_d  = sel_data;
            last_d  = sel_last;
            valid_d = 1'b1;
        end else if (m_axis_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
        end
    end

    assign m_axis_data  = data_q;
    assign m_axis_valid = valid_q;
    assign m_axis_last  = last_q;
    assign grant_id     = grant_q;
    assign busy         = (state_q == PKT);
    assign pkt_count    = cnt_q;

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter with scripted packet sources.
module tb_axis_pkt_rr_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NS*DW-1:0]  s_axis_data;
    logic [NS-1:0]     s_axis_valid;
    logic [NS-1:0]     s_axis_last;
    logic [NS-1:0]     s_axis_ready;
    logic [DW-1:0]     m_axis_data;
    logic              m_axis_valid;
    logic              m_axis_last;
    logic              m_axis_ready;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic [15:0]       pkt_count;

    always #5 clk = ~clk;

    axis_pkt_rr_arbiter #(
        .NUM_SRC    (NS),
        .DATA_WIDTH (DW),
        .ID_W       (IW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_last  (m_axis_last),
        .m_axis_ready (m_axis_ready),
        .grant_id     (grant_id),
        .busy         (busy),
        .pkt_count    (pkt_count)
    );

    int total = 0;
    int bad   = 0;

    // scripted sources: packets left, beats per packet, current beat, data base
    int          src_left [NS];
    int          src_len  [NS];
    int          src_beat [NS];
    logic [DW-1:0] src_base [NS];
    int          stall_src;
    int          stall_beat;
    int          stall_left;
    logic [NS-1:0] acc;
    int          ncyc = 0;
    bit          use_pat;
    logic        mr;

    logic [DW-1:0] obs_data [$];
    logic          obs_last [$];
    int            obs_cyc  [$];

    task automatic clear_model();
        for (int i = 0; i < NS; i++) begin
            src_left[i] = 0;
            src_len[i]  = 1;
            src_beat[i] = 0;
            src_base[i] = '0;
        end
        stall_src  = -1;
        stall_beat = 0;
        stall_left = 0;
        acc        = '0;
        use_pat    = 1'b0;
        mr         = 1'b1;
        obs_data.delete();
        obs_last.delete();
        obs_cyc.delete();
    endtask

    // one clock: advance sources on accepted beats, drive new inputs, log output transfers
    task automatic cycle();
        logic v;
        @(posedge clk);
        #1;
        ncyc++;
        if (reset_n === 1'b1) begin
            for (int i = 0; i < NS; i++) begin
                if (acc[i]) begin
                    if (src_beat[i] == src_len[i] - 1) begin
                        src_beat[i] = 0;
                        src_left[i] = src_left[i] - 1;
                    end else begin
                        src_beat[i] = src_beat[i] + 1;
                    end
                end
            end
        end
        for (int i = 0; i < NS; i++) begin
            v = (src_left[i] > 0);
            if (v && i == stall_src && src_beat[i] == stall_beat && stall_left > 0) begin
                v = 1'b0;
                stall_left = stall_left - 1;
            end
            s_axis_valid[i]             = v;
            s_axis_last[i]              = (src_beat[i] == src_len[i] - 1);
            s_axis_data[i*DW +: DW]     = src_base[i] + DW'(src_beat[i]);
        end
        m_axis_ready = use_pat ? ((ncyc % 4 == 0) || (ncyc % 4 == 3)) : mr;
        #1;
        acc = (reset_n === 1'b1) ? (s_axis_valid & s_axis_ready) : '0;
        if (m_axis_valid === 1'b1 && m_axis_ready === 1'b1) begin
            obs_data.push_back(m_axis_data);
            obs_last.push_back(m_axis_last);
            obs_cyc.push_back(ncyc);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_model();
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_model();
        for (int i = 0; i < NS; i++) begin
            src_left[i] = 1;
            src_len[i]  = 2;
            src_base[i] = DW'(i * 16);
        end
        reset_n = 1'b0;
        repeat (3) cycle();
        total++; if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", m_axis_valid); end
        total++; if (m_axis_last !== 1'b0) begin bad++; $display("FAIL reset_m_last: got %b want 0", m_axis_last); end
        total++; if (m_axis_data !== '0) begin bad++; $display("FAIL reset_m_data: got %h want 0", m_axis_data); end
        total++; if (s_axis_ready !== '0) begin bad++; $display("FAIL reset_s_ready: got %b want 0000", s_axis_ready); end
        total++; if (grant_id !== '0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
        reset_n = 1'b1;
        cycle();
        total++; if (grant_id !== 4'd0) begin bad++; $display("FAIL release_grant: got %0d want 0", grant_id); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL release_busy: got %b want 1", busy); end
        total++; if (s_axis_ready !== 4'b0001) begin bad++; $display("FAIL release_s_ready: got %b want 0001", s_axis_ready); end
    endtask

    task automatic test_fairness();
        int seq [5] = '{0, 1, 2, 3, 0};
        logic [DW-1:0] exp_d;
        do_reset();
        for (int i = 0; i < NS; i++) begin
            src_left[i] = 2;
            src_len[i]  = 2;
            src_base[i] = DW'(i * 16);
        end
        for (int c = 0; c < 80 && obs_data.size() < 10; c++) cycle();
        if (obs_data.size() < 10) begin
            total++; bad++;
            $display("FAIL rr_timeout: got %0d beats want 10", obs_data.size());
            return;
        end
        total++; if (pkt_count !== 16'd5) begin bad++; $display("FAIL rr_pkt_count: got %0d want 5", pkt_count); end
        for (int k = 0; k < 10; k++) begin
            exp_d = DW'(seq[k/2] * 16 + (k % 2));
            total++;
            if (obs_data[k] !== exp_d || obs_last[k] !== (k % 2 == 1)) begin
                bad++;
                $display("FAIL rr_beat%0d: got data=%h last=%b want data=%h last=%b", k, obs_data[k], obs_last[k], exp_d, (k % 2 == 1));
            end
        end
        for (int p = 0; p < 5; p++) begin
            total++;
            if (obs_cyc[2*p+1] !== obs_cyc[2*p] + 1) begin
                bad++;
                $display("FAIL rr_contig_pkt%0d: got gap %0d want 1", p, obs_cyc[2*p+1] - obs_cyc[2*p]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic          pv, pr, pl;
        logic [DW-1:0] pd;
        int            holds = 0;
        do_reset();
        src_left[2] = 1;
        src_len[2]  = 4;
        src_base[2] = 32'hA0;
        use_pat     = 1'b1;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        for (int c = 0; c < 60 && obs_data.size() < 4; c++) begin
            cycle();
            if (pv && !pr) begin
                holds++;
                total++;
                if ({m_axis_valid, m_axis_data, m_axis_last} !== {1'b1, pd, pl}) begin
                    bad++;
                    $display("FAIL bp_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b", m_axis_valid, m_axis_data, m_axis_last, pd, pl);
                end
            end
            pv = m_axis_valid; pr = m_axis_ready; pd = m_axis_data; pl = m_axis_last;
        end
        use_pat = 1'b0;
        if (obs_data.size() < 4) begin
            total++; bad++;
            $display("FAIL bp_timeout: got %0d beats want 4", obs_data.size());
            return;
        end
        total++; if (holds == 0) begin bad++; $display("FAIL bp_no_stall: got 0 held cycles want >0"); end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs_data[k] !== DW'(32'hA0 + k) || obs_last[k] !== (k == 3)) begin
                bad++;
                $display("FAIL bp_beat%0d: got data=%h last=%b want data=%h last=%b", k, obs_data[k], obs_last[k], 32'hA0 + k, (k == 3));
            end
        end
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL bp_pkt_count: got %0d want 1", pkt_count); end
    endtask

    task automatic test_single_beat();
        bit got;
        do_reset();
        src_left[1] = 4;
        src_len[1]  = 1;
        src_base[1] = 32'h50;
        for (int c = 0; c < 40 && obs_data.size() < 4; c++) begin
            cycle();
            if (busy === 1'b1) begin
                total++;
                if (grant_id !== 4'd1) begin bad++; $display("FAIL sb_grant: got %0d want 1", grant_id); end
            end
        end
        if (obs_data.size() < 4) begin
            total++; bad++;
            $display("FAIL sb_timeout: got %0d beats want 4", obs_data.size());
            return;
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs_data[k] !== 32'h50 || obs_last[k] !== 1'b1) begin
                bad++;
                $display("FAIL sb_beat%0d: got data=%h last=%b want data=00000050 last=1", k, obs_data[k], obs_last[k]);
            end
        end
        for (int k = 1; k < 4; k++) begin
            total++;
            if (obs_cyc[k] - obs_cyc[k-1] !== 2) begin
                bad++;
                $display("FAIL sb_spacing%0d: got %0d cycles want 2", k, obs_cyc[k] - obs_cyc[k-1]);
            end
        end
        total++; if (pkt_count !== 16'd4) begin bad++; $display("FAIL sb_pkt_count: got %0d want 4", pkt_count); end
        repeat (2) cycle();
        src_left[0] = 1; src_base[0] = 32'h60;
        src_left[2] = 1; src_base[2] = 32'h70;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            cycle();
            got = (busy === 1'b1);
        end
        total++;
        if (!got) begin bad++; $display("FAIL sb_next_timeout: got busy=0 want 1"); end
        else if (grant_id !== 4'd2) begin bad++; $display("FAIL sb_ptr_after: got %0d want 2", grant_id); end
    endtask

    task automatic test_mid_stall();
        logic [DW-1:0] exp_d [4] = '{32'hC0, 32'hC1, 32'hC2, 32'hD0};
        logic          exp_l [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        src_left[0] = 1; src_len[0] = 3; src_base[0] = 32'hC0;
        src_left[3] = 1; src_len[3] = 1; src_base[3] = 32'hD0;
        stall_src  = 0;
        stall_beat = 1;
        stall_left = 6;
        for (int c = 0; c < 60 && obs_data.size() < 4; c++) begin
            cycle();
            if (src_left[0] > 0) begin
                total++;
                if (s_axis_ready[3] !== 1'b0) begin bad++; $display("FAIL stall_ready3: got %b want 0", s_axis_ready[3]); end
            end
            if (src_left[0] > 0 && s_axis_valid[0] === 1'b0) begin
                total++;
                if (grant_id !== 4'd0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_lock: got grant=%0d busy=%b want grant=0 busy=1", grant_id, busy);
                end
            end
        end
        if (obs_data.size() < 4) begin
            total++; bad++;
            $display("FAIL stall_timeout: got %0d beats want 4", obs_data.size());
            return;
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (obs_data[k] !== exp_d[k] || obs_last[k] !== exp_l[k]) begin
                bad++;
                $display("FAIL stall_beat%0d: got data=%h last=%b want data=%h last=%b", k, obs_data[k], obs_last[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        do_reset();
        src_left[1] = 1; src_len[1] = 1; src_base[1] = 32'h10;
        for (int c = 0; c < 10 && pkt_count !== 16'd1; c++) cycle();
        total++; if (pkt_count !== 16'd1) begin bad++; $display("FAIL rm_first_pkt: got %0d want 1", pkt_count); end
        src_left[2] = 1; src_len[2] = 4; src_base[2] = 32'hE0;
        for (int c = 0; c < 20 && src_beat[2] != 2; c++) cycle();
        total++; if (src_beat[2] != 2) begin bad++; $display("FAIL rm_timeout: got beat %0d want 2", src_beat[2]); end
        reset_n = 1'b0;
        cycle();
        total++; if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL rm_m_valid: got %b want 0", m_axis_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy: got %b want 0", busy); end
        total++; if (pkt_count !== 16'd0) begin bad++; $display("FAIL rm_pkt_count: got %0d want 0", pkt_count); end
        total++; if (s_axis_ready !== '0) begin bad++; $display("FAIL rm_s_ready: got %b want 0000", s_axis_ready); end
        clear_model();
        cycle();
        reset_n = 1'b1;
        src_left[0] = 1; src_base[0] = 32'h01;
        src_left[3] = 1; src_base[3] = 32'h31;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            cycle();
            got = (busy === 1'b1);
        end
        total++;
        if (!got) begin bad++; $display("FAIL rm_regrant_timeout: got busy=0 want 1"); end
        else if (grant_id !== 4'd0) begin bad++; $display("FAIL rm_regrant: got %0d want 0", grant_id); end
    endtask

    initial begin
        reset_n      = 1'b0;
        s_axis_valid = '0;
        s_axis_last  = '0;
        s_axis_data  = '0;
        m_axis_ready = 1'b0;
        clear_model();
        test_reset();
        test_fairness();
        test_backpressure();
        test_single_beat();
        test_mid_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_pkt_rr_arbiter.md
Name: axis_pkt_rr_arbiter

Overview:
- Packet-aware round-robin arbiter that merges NUM_SRC AXI-Stream sources into one AXI-Stream output feeding the fifo_ff write side.
- Holds a grant for a whole packet, from the first beat to the beat with last, so packets never interleave in the FIFO.
- Output is a single registered stage to break the ready/valid timing path into the FIFO.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16, need not be a power of two)
- DATA_WIDTH, 32, tdata width per source
- ID_W, 4, width of grant_id (must satisfy 2^ID_W >= NUM_SRC)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- s_axis_data  in  NUM_SRC*DATA_WIDTH  source data, source i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_valid  in  NUM_SRC  per-source valid
- s_axis_last  in  NUM_SRC  per-source last
- s_axis_ready  out  NUM_SRC  per-source ready; one-hot or zero
- m_axis_data  out  DATA_WIDTH  registered output data
- m_axis_valid  out  1  registered output valid
- m_axis_last  out  1  registered output last
- m_axis_ready  in  1  downstream ready (FIFO)
- grant_id  out  ID_W  index of the currently or last granted source
- busy  out  1  high while in the PKT state
- pkt_count  out  16  count of packets completed on the output; wraps at 65535->0

Behaviour:
- Reset (reset_n=0 at posedge clk):
  - m_axis_valid=0, m_axis_last=0, m_axis_data=0, s_axis_ready=0, grant_id=0, busy=0, pkt_count=0.
  - rr_ptr=0 and state=IDLE.
  - A packet in flight is abandoned; the output register is cleared.
- States:
  - IDLE: if any s_axis_valid bit is set, select the first index j at or after rr_ptr, cyclically modulo NUM_SRC, with s_axis_valid[j]=1. Then grant_id<=j and go to PKT. No beat is accepted in IDLE. Arbitration costs exactly 1 cycle.
  - PKT: s_axis_ready[grant_id] = (!m_axis_valid || m_axis_ready). All other ready bits are 0.
- Beat acceptance: a beat is accepted when s_axis_valid[g] && s_axis_ready[g]. The output register loads data and last and sets m_axis_valid=1 on the next edge. Input to output latency is 1 cycle.
- Output hold: when m_axis_valid && !m_axis_ready, data, last and valid hold stable. m_axis_valid clears only after a transfer with no new beat loaded.
- Full throughput: with m_axis_ready=1 held, one beat per cycle.
- Packet end: an accepted beat with last=1 sets rr_ptr<=(g+1 mod NUM_SRC), returns to IDLE and increments pkt_count in the same edge. Wrap at NUM_SRC-1 goes to 0, including non-power-of-two NUM_SRC.
- Grant is locked: if the granted source drops valid mid-packet, the grant is held indefinitely. Other sources are not served.
- Single-beat packet (valid and last on the first beat): IDLE, then 1 PKT cycle, then IDLE. Minimum 2 cycles per packet per grant.
- All sources valid continuously: grant order 0,1,2,3,0,...
- Only source k valid: k is re-granted every time.
- busy=1 exactly while state=PKT.
- grant_id holds its value in IDLE until the next grant.

Decomposition:
- Package axis_arb_pkg: state enum (IDLE, PKT) and the pkt_count width constant (16).
- Sub-module rr_pick: combinational rotating-priority selector. Inputs: req[NUM_SRC], ptr[ID_W]. Outputs: idx[ID_W], found. Instantiated once in the arbiter.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with all valids=1 -> all outputs 0 and s_axis_ready=0. On release, grant_id=0 one cycle after and busy=1.
- Round-robin fairness, NUM_SRC=4: all sources send 2-beat packets continuously, m_axis_ready=1 -> output source order 0,1,2,3,0. pkt_count=5 after 5 packets. Beats contiguous within each packet.
- Backpressure: source 2 sends 4-beat packet 0xA0..0xA3 with m_axis_ready toggling 1,0,0,1,... -> m_axis_data holds each value stable while ready=0. Order A0..A3 exact. m_axis_last=1 only with A3.
- Single-beat packets: source 1 only, valid=last=1 continuously -> one output beat every 2 cycles. rr_ptr ends at 2, yet source 1 is re-granted each time.
- Mid-packet stall: source 0 drops valid after beat 1 of 3 while source 3 is valid -> source 3 receives no ready until source 0 completes its packet with last.
- Reset mid-packet: assert reset_n=0 during beat 2 of a 4-beat packet -> next cycle m_axis_valid=0, busy=0, pkt_count=0. The next grant starts from source 0.
